// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with hold limit; ports clk, rst_n, en, req[7:0] -> gnt[7:0], gnt_idx[2:0], gnt_valid, gnt_start
module rr_arbiter8 #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       gnt_start
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, idx_n, base, sel;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [7:0] gnt_n;
  logic valid_n, start_n, rel, go;
  // in GRANT the search always starts just past the current holder, so a timed-out holder comes last
  assign base = state == GRANT ? gnt_idx + 3'd1 : ptr;
  assign rel = !req[gnt_idx] || hold_cnt == HOLD_W'(MAX_HOLD) || !en;
  assign go = en && |req;
  always_comb begin
    sel = base;
    for (int k = 7; k >= 0; k--)
      if (req[base + 3'(k)]) sel = base + 3'(k);
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    hold_n = hold_cnt;
    gnt_n = gnt;
    idx_n = gnt_idx;
    valid_n = gnt_valid;
    start_n = 1'b0;
    if (state == GRANT && !rel) hold_n = hold_cnt + HOLD_W'(1);
    else if (state == GRANT || go) begin
      ptr_n = state == GRANT ? base : ptr;
      if (go) begin
        state_n = GRANT;
        gnt_n = 8'b1 << sel;
        idx_n = sel;
        valid_n = 1'b1;
        start_n = 1'b1;
        hold_n = HOLD_W'(1);
      end else begin
        state_n = IDLE;
        gnt_n = '0;
        valid_n = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      gnt <= '0;
      gnt_idx <= '0;
      gnt_valid <= 1'b0;
      gnt_start <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      hold_cnt <= hold_n;
      gnt <= gnt_n;
      gnt_idx <= idx_n;
      gnt_valid <= valid_n;
      gnt_start <= start_n;
    end
endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Sequential round-robin arbiter sharing one resource between 8 requesters.
- Output is a registered grant, given both one-hot and as a 3-bit encoded index, in the same format as the 8-to-3 encoder with enable.
- Sits in front of a shared datapath. Grant tenure ends on requester release, on a hold-time limit, or when enable is removed.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant. Legal range 1..15.
- HOLD_W, 4, width of the hold counter. Must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  arbiter enable; 0 blocks new grants and terminates the current one
- req  input  8  request vector; bit i = requester i
- gnt  output  8  one-hot grant, registered; all-zero when idle
- gnt_idx  output  3  encoded index of the granted requester, registered
- gnt_valid  output  1  1 while a grant is held
- gnt_start  output  1  one-cycle pulse in the first cycle of every grant tenure, including a re-grant to the same requester

Behaviour:
- Reset (rst_n=0, takes effect immediately, asynchronously):
  - state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, gnt_start=0.
  - Priority pointer ptr=0, hold_cnt=0.
- Selection function: first i in circular order ptr, ptr+1, ..., ptr+7 (mod 8) with req[i]=1.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0 at a rising edge: at that edge gnt=onehot(sel), gnt_idx=sel, gnt_valid=1, gnt_start=1, hold_cnt=1; go to GRANT.
  - Latency from request sample to visible grant is one edge.
  - Otherwise remain in IDLE with outputs unchanged.
- GRANT, each edge, with g = gnt_idx:
  - gnt_start=0.
  - Release condition: req[g]=0, or hold_cnt==MAX_HOLD, or en=0.
  - No release: hold_cnt=hold_cnt+1; outputs hold.
  - On release: ptr=(g+1) mod 8, 3-bit wrap, so 7 wraps to 0.
  - Then, at the same edge, with the new ptr: if en=1 and req!=0, grant sel immediately (back-to-back, no idle cycle). This sets gnt_start=1 and hold_cnt=1, and the state stays GRANT.
  - Otherwise: gnt=0, gnt_valid=0, go to IDLE. gnt_idx keeps its last value.
- Requester g is re-granted after a timeout only when no other request is active; it comes last in the circular order.
- Invariants:
  - gnt is always zero or one-hot.
  - When gnt_valid=1, gnt == (1 << gnt_idx).
  - hold_cnt never exceeds MAX_HOLD.
- Changes to req bits other than req[g] during a tenure do not affect the current grant.
- MAX_HOLD=1: every grant lasts exactly one cycle, and the pointer rotates every cycle.
- en=0 in the same cycle as a new request in IDLE: no grant.
- rst_n asserted mid-tenure: all outputs clear asynchronously, and after reset the pointer restarts at 0.

Test Plan:
- Reset mid-grant: grant held on idx 5, then rst_n=0 between clock edges -> gnt=8'h00, gnt_valid=0, gnt_idx=0 immediately, without waiting for a clock edge. After release, req=8'hFF -> gnt_idx=0.
- Enable gating: en=0, req=8'hFF for 10 cycles -> gnt_valid=0 throughout. Raise en -> one edge later gnt=8'h01, gnt_idx=0, gnt_start=1.
- Single requester, voluntary release: req=8'h10 for 3 cycles, then 8'h00 -> gnt=8'h10, gnt_idx=4 for 3 cycles. At the edge after the drop: gnt=0, gnt_valid=0. Next grant search starts at ptr=5.
- Timeout rotation, MAX_HOLD=4: req held at 8'h81 -> grant sequence idx0 (4 cycles), idx7 (4), idx0 (4), ... with no gap cycles and gnt_start pulsing at each switch. The wrap from 7 to 0 is checked.
- Sole-requester re-grant: req=8'h04 held for 12 cycles -> gnt_idx=2, gnt_valid continuously 1, gnt_start pulses every 4 cycles.
- Full rotation: req=8'hFF held, each granted requester drops its bit for one cycle after 1 cycle of grant -> gnt_idx sequence 0,1,2,...,7,0. Checkers confirm gnt is one-hot and consistent with gnt_idx every cycle.
